sr_display_rx: RTL and testbench

- Receive end of the display serial link: accepts the serial clock, data and latch lines driven by the display shift-register/controller path and reconstructs the frame.
- Oversamples all three lines in the i_clk domain and shifts one bit per serial-clock rising edge.
- Commits the frame on latch, then decodes each 7-segment byte back to BCD.
- Used as the display-side model/driver and as the checker in system benches.

---
 rtl/sr_display_rx.sv | 141 ++++++++++++++
 tb/tb_sr_display_rx.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/sr_display_rx.sv
`default_nettype none
// ============================================================================
// Module   : sr_display_rx
// Brief    : Display serial-link receiver. Oversamples sclk/sdata/latch,
//            rebuilds the segment frame and decodes each 7-segment byte to BCD.
// Revision : 1.0 - initial release
// ============================================================================
module sr_display_rx #(
    parameter int DIGITS      = 6,
    parameter int SEG_BITS    = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_sclk,
    input  logic                         i_sdata,
    input  logic                         i_latch,
    output logic [DIGITS*SEG_BITS-1:0]   o_segments,
    output logic [DIGITS*4-1:0]          o_bcd,
    output logic                         o_bcd_ok,
    output logic                         o_valid,
    output logic                         o_frame_err,
    output logic                         o_busy
);

    localparam int            c_N       = DIGITS * SEG_BITS;
    localparam int            c_CW      = $clog2(c_N + 2);
    localparam logic [c_CW-1:0] c_CNT_FULL = c_CW'(c_N);
    localparam logic [c_CW-1:0] c_CNT_MAX  = c_CW'(c_N + 1);

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_sdata_sync;
    logic [SYNC_STAGES-1:0] r_latch_sync;
    logic                   r_sclk_prev;
    logic                   r_latch_prev;
    logic [c_N-1:0]         r_shift;
    logic [c_CW-1:0]        r_cnt;

    logic                   w_sclk_rise;
    logic                   w_latch_rise;
    logic [c_N-1:0]         w_shift_next;
    logic [c_CW-1:0]        w_cnt_next;
    logic [c_N-1:0]         w_map;
    logic [DIGITS*4-1:0]    w_dec;
    logic [DIGITS-1:0]      w_legal;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sclk_sync  <= '0;
            r_sdata_sync <= '0;
            r_latch_sync <= '0;
            r_sclk_prev  <= 1'b0;
            r_latch_prev <= 1'b0;
        end else begin
            r_sclk_sync  <= {r_sclk_sync[SYNC_STAGES-2:0],  i_sclk};
            r_sdata_sync <= {r_sdata_sync[SYNC_STAGES-2:0], i_sdata};
            r_latch_sync <= {r_latch_sync[SYNC_STAGES-2:0], i_latch};
            r_sclk_prev  <= r_sclk_sync[SYNC_STAGES-1];
            r_latch_prev <= r_latch_sync[SYNC_STAGES-1];
        end
    end

    assign w_sclk_rise  = r_sclk_sync[SYNC_STAGES-1]  & ~r_sclk_prev;
    assign w_latch_rise = r_latch_sync[SYNC_STAGES-1] & ~r_latch_prev;

    // The shift is resolved before the latch looks at it, so a coincident
    // sclk/latch rise commits the post-shift frame.
    always_comb begin
        w_shift_next = r_shift;
        w_cnt_next   = r_cnt;
        if (w_sclk_rise) begin
            w_shift_next = {r_shift[c_N-2:0], r_sdata_sync[SYNC_STAGES-1]};
            if (r_cnt != c_CNT_MAX) begin
                w_cnt_next = r_cnt + 1'b1;
            end
        end
    end

    for (genvar k = 0; k < DIGITS; k++) begin : g_map
        assign w_map[SEG_BITS*k +: SEG_BITS] = w_shift_next[c_N-1-SEG_BITS*k -: SEG_BITS];
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_shift     <= '0;
            r_cnt       <= '0;
            o_segments  <= '0;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            r_shift     <= w_shift_next;
            r_cnt       <= w_cnt_next;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
            if (w_latch_rise) begin
                r_cnt <= '0;
                if (w_cnt_next == c_CNT_FULL) begin
                    o_segments <= w_map;
                    o_valid    <= 1'b1;
                end else begin
                    o_frame_err <= 1'b1;
                end
            end
        end
    end

    // Decoder works on the committed frame; dp (bit 7) never takes part.
    for (genvar k = 0; k < DIGITS; k++) begin : g_dec
        always_comb begin
            w_dec[4*k +: 4] = 4'hF;
            w_legal[k]      = 1'b1;
            case (o_segments[SEG_BITS*k +: 7])
                7'h3F:   w_dec[4*k +: 4] = 4'd0;
                7'h06:   w_dec[4*k +: 4] = 4'd1;
                7'h5B:   w_dec[4*k +: 4] = 4'd2;
                7'h4F:   w_dec[4*k +: 4] = 4'd3;
                7'h66:   w_dec[4*k +: 4] = 4'd4;
                7'h6D:   w_dec[4*k +: 4] = 4'd5;
                7'h7D:   w_dec[4*k +: 4] = 4'd6;
                7'h07:   w_dec[4*k +: 4] = 4'd7;
                7'h7F:   w_dec[4*k +: 4] = 4'd8;
                7'h6F:   w_dec[4*k +: 4] = 4'd9;
                default: w_legal[k]      = 1'b0;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_bcd    <= '0;
            o_bcd_ok <= 1'b0;
        end else if (o_valid) begin
            o_bcd    <= w_dec;
            o_bcd_ok <= &w_legal;
        end
    end

    assign o_busy = (r_cnt != '0);

endmodule
`default_nettype wire

// File: tb/tb_sr_display_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_sr_display_rx
// Brief    : Scoreboard bench for sr_display_rx with directed frames.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sr_display_rx;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_sclk = 1'b0;
    logic        i_sdata = 1'b0;
    logic        i_latch = 1'b0;
    logic [47:0] o_segments;
    logic [23:0] o_bcd;
    logic        o_bcd_ok;
    logic        o_valid;
    logic        o_frame_err;
    logic        o_busy;

    sr_display_rx #(.DIGITS(6), .SEG_BITS(8), .SYNC_STAGES(2)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_sclk      (i_sclk),
        .i_sdata     (i_sdata),
        .i_latch     (i_latch),
        .o_segments  (o_segments),
        .o_bcd       (o_bcd),
        .o_bcd_ok    (o_bcd_ok),
        .o_valid     (o_valid),
        .o_frame_err (o_frame_err),
        .o_busy      (o_busy)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        bit          is_err;
        logic [47:0] seg;
        logic [23:0] bcd;
        bit          ok;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    logic [47:0] exp_seg = '0;
    logic [23:0] exp_bcd = '0;
    bit          exp_ok  = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    // Stream is given first-bit-first from its MSB; bits[n-1] goes out first.
    task automatic send_bits(input logic [63:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            i_sdata = bits[i];
            cyc(1);
            i_sclk = 1'b1;
            cyc(4);
            i_sclk = 1'b0;
            cyc(3);
        end
    endtask

    task automatic do_latch();
        i_latch = 1'b1;
        cyc(4);
        i_latch = 1'b0;
        cyc(4);
    endtask

    task automatic push_good(input logic [47:0] seg, input logic [23:0] bcd, input bit ok);
        exp_t e;
        exp_seg = seg;
        exp_bcd = bcd;
        exp_ok  = ok;
        e.is_err = 1'b0; e.seg = seg; e.bcd = bcd; e.ok = ok;
        q.push_back(e);
    endtask

    task automatic push_err();
        exp_t e;
        e.is_err = 1'b1; e.seg = exp_seg; e.bcd = exp_bcd; e.ok = exp_ok;
        q.push_back(e);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (q.size() != 0 && n < 80) begin
            cyc(1);
            n++;
        end
        cyc(2);
        chk({name, "_drain"}, 64'(q.size()), 64'd0);
        q.delete();
    endtask

    // Monitor: every output pulse pops one expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge i_clk);
            if (o_valid || o_frame_err) begin
                chk("pulse_exclusive", 64'(o_valid & o_frame_err), 64'd0);
                if (q.size() == 0) begin
                    chk("unexpected_pulse", {62'd0, o_valid, o_frame_err}, 64'd0);
                end else begin
                    e = q.pop_front();
                    chk("pulse_kind_err", 64'(o_frame_err), 64'(e.is_err));
                    chk("segments", 64'(o_segments), 64'(e.seg));
                    @(negedge i_clk);
                    chk("pulse_one_cycle", 64'(o_valid | o_frame_err), 64'd0);
                    chk("bcd", 64'(o_bcd), 64'(e.bcd));
                    chk("bcd_ok", 64'(o_bcd_ok), 64'(e.ok));
                end
            end
        end
    end

    initial begin
        // Reset state
        cyc(3);
        @(negedge i_clk);
        chk("rst_segments", 64'(o_segments), 64'd0);
        chk("rst_bcd", 64'(o_bcd), 64'd0);
        chk("rst_bcd_ok", 64'(o_bcd_ok), 64'd0);
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_frame_err", 64'(o_frame_err), 64'd0);
        chk("rst_busy", 64'(o_busy), 64'd0);
        i_rst = 1'b0;
        cyc(3);

        // Good frame: 6D 66 4F 5B 06 3F
        send_bits(64'(48'h6D664F5B063F), 48);
        @(negedge i_clk);
        chk("busy_full", 64'(o_busy), 64'd1);
        push_good(48'h3F065B4F666D, 24'h012345, 1'b1);
        do_latch();
        drain("good1");
        chk("busy_after_commit", 64'(o_busy), 64'd0);

        // Short frame (47 bits)
        send_bits(64'(48'h3F065B4F666D) >> 1, 47);
        @(negedge i_clk);
        chk("busy_short", 64'(o_busy), 64'd1);
        push_err();
        do_latch();
        drain("short");
        chk("busy_after_short", 64'(o_busy), 64'd0);

        // Full frame following the short one: 3F 06 5B 4F 66 6D
        send_bits(64'(48'h3F065B4F666D), 48);
        push_good(48'h6D664F5B063F, 24'h543210, 1'b1);
        do_latch();
        drain("good2");

        // Long frame (52 bits): counter saturates at 49
        send_bits({48'h6D664F5B063F, 4'hA}, 52);
        @(negedge i_clk);
        chk("count_saturated", 64'(dut.r_cnt), 64'd49);
        push_err();
        do_latch();
        drain("long");
        chk("busy_after_long", 64'(o_busy), 64'd0);

        // Bare latch
        push_err();
        do_latch();
        drain("bare");

        // Illegal byte 2 and dp on a legal zero: 7F 6F 00 07 7D BF
        send_bits(64'(48'h7F6F00077DBF), 48);
        push_good(48'hBF7D07006F7F, 24'h067F98, 1'b0);
        do_latch();
        drain("illegal");

        // 48th sclk rise coincides with the latch rise: 66 66 66 66 66 07
        send_bits(64'(48'h666666666607) >> 1, 47);
        push_good(48'h076666666666, 24'h744444, 1'b1);
        i_sdata = 1'b1;
        cyc(1);
        i_sclk  = 1'b1;
        i_latch = 1'b1;
        cyc(4);
        i_sclk  = 1'b0;
        i_latch = 1'b0;
        cyc(4);
        drain("simul");
        chk("busy_after_simul", 64'(o_busy), 64'd0);

        // Reset mid-frame
        send_bits(64'(48'h6D664F5B063F) >> 28, 20);
        @(posedge i_clk);
        #2 i_rst = 1'b1;
        #1;
        chk("async_rst_segments", 64'(o_segments), 64'd0);
        chk("async_rst_bcd", 64'(o_bcd), 64'd0);
        chk("async_rst_bcd_ok", 64'(o_bcd_ok), 64'd0);
        chk("async_rst_busy", 64'(o_busy), 64'd0);
        exp_seg = '0; exp_bcd = '0; exp_ok = 1'b0;
        cyc(3);
        i_rst = 1'b0;
        cyc(3);
        send_bits(64'(48'h6D664F5B063F), 48);
        push_good(48'h3F065B4F666D, 24'h012345, 1'b1);
        do_latch();
        drain("after_reset");
        chk("busy_final", 64'(o_busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
